// File: rtl/led_pkg.sv
// Shared types and constants for the status-LED blink-code scheduler.
package led_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} led_state_t;

    // Largest of three tick counts; sizes the per-phase tick counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: pulses tick every TICK_CYC cycles and restarts from 0 on clr.
module led_tick_gen #(
    parameter int TICK_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(TICK_CYC - 1));

    // Free-running 0..TICK_CYC-1 counter; clr realigns it to a phase start.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            r_cnt <= '0;
        else if (tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/led_code_sched.sv
// Blink-code scheduler: fixed-priority arbitration between requesters, then
// N short blinks followed by a long gap on the status LED.
module led_code_sched
    import led_pkg::*;
#(
    parameter int FREQ      = 100000000,
    parameter int TICK_CYC  = FREQ / 10,
    parameter int NREQ      = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 8,
    localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NREQ-1:0]          req,
    input  logic [CODE_W*NREQ-1:0]   code,
    output logic                     led_out,
    output logic [GW-1:0]            grant_id,
    output logic                     seq_active,
    output logic                     seq_done
);

    localparam int PT_W = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

    led_state_t        r_state, w_nxt;
    logic [CODE_W-1:0] r_code_l, r_blink;
    logic [PT_W-1:0]   r_ptick, w_lim;
    logic [GW-1:0]     r_gid, w_gnt_id;
    logic [CODE_W-1:0] w_gnt_code;
    logic              w_gnt_vld;
    logic              r_led, r_act, r_done;
    logic              w_tick, w_clr, w_phase_end, w_grant;

    // Prescaler restarts on every state entry and is held cleared while idle.
    led_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Priority encoder: scan high to low so the lowest eligible index wins.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_id   = '0;
        w_gnt_code = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (code[i*CODE_W +: CODE_W] != '0)) begin
                w_gnt_vld  = 1'b1;
                w_gnt_id   = GW'(i);
                w_gnt_code = code[i*CODE_W +: CODE_W];
            end
        end
    end

    // Last tick index of the current phase.
    always_comb begin
        w_lim = '0;
        case (r_state)
            ON:      w_lim = PT_W'(ON_TICKS - 1);
            OFF:     w_lim = PT_W'(OFF_TICKS - 1);
            GAP:     w_lim = PT_W'(GAP_TICKS - 1);
            default: w_lim = '0;
        endcase
    end

    assign w_phase_end = w_tick && (r_ptick == w_lim);
    assign w_grant     = (r_state == IDLE) && en && w_gnt_vld;

    // Next-state logic; en low aborts from any state straight back to IDLE.
    always_comb begin
        w_nxt = r_state;
        if (!en) begin
            w_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_gnt_vld)   w_nxt = ON;
                ON:   if (w_phase_end) w_nxt = OFF;
                // r_blink already counts the blink just finished, so the
                // compare never lets the 4-bit counter pass the latched code.
                OFF:  if (w_phase_end) w_nxt = (r_blink < r_code_l) ? ON : GAP;
                GAP:  if (w_phase_end) w_nxt = IDLE;
                default: w_nxt = IDLE;
            endcase
        end
    end

    assign w_clr = (w_nxt != r_state) || (r_state == IDLE);

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_led   <= 1'b0;
            r_act   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_led   <= (w_nxt == ON);
            r_act   <= (w_nxt != IDLE);
            r_done  <= (r_state == GAP) && en && w_phase_end;
        end
    end

    // Ticks elapsed within the current phase.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clr)
            r_ptick <= '0;
        else if (w_tick)
            r_ptick <= r_ptick + 1'b1;
    end

    // Grant latch and blink counter; grant_id is held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gid    <= '0;
            r_code_l <= '0;
            r_blink  <= '0;
        end else if (w_grant) begin
            r_gid    <= w_gnt_id;
            r_code_l <= w_gnt_code;
            r_blink  <= '0;
        end else if ((r_state == ON) && (w_nxt == OFF)) begin
            r_blink  <= r_blink + 1'b1;
        end
    end

    assign led_out    = r_led;
    assign seq_active = r_act;
    assign seq_done   = r_done;
    assign grant_id   = r_gid;

endmodule

// File: tb/tb_led_code_sched.sv
// Directed bench for led_code_sched with a scoreboard of {grant id, blinks}
// per completed sequence plus cycle-exact output checks.
module tb_led_code_sched;

    localparam int NREQ = 4;
    localparam int TC   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [4*NREQ-1:0]    code = '0;
    logic                 led_out, seq_active, seq_done;
    logic [1:0]           grant_id;

    typedef struct {int id; int n;} exp_t;
    exp_t sb[$];

    int   errors = 0;
    int   checks = 0;
    int   blinks = 0;
    int   on_cyc = 0;
    logic prev_led = 1'b0;

    always #5 clk = ~clk;

    led_code_sched #(
        .FREQ(40), .TICK_CYC(TC), .NREQ(NREQ),
        .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .code(code),
        .led_out(led_out), .grant_id(grant_id),
        .seq_active(seq_active), .seq_done(seq_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_code(input int i, input int v);
        code[4*i +: 4] = 4'(v);
    endtask

    // Advance one clock, sample 2 ns after the edge, and run the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #2;
        if (led_out === 1'b1 && prev_led !== 1'b1) blinks++;
        prev_led = led_out;
        if (seq_done === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done: observed done with %0d queued, expected >0", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_id", 32'(grant_id), 32'(e.id));
                chk("sb_blinks", 32'(blinks), 32'(e.n));
            end
            blinks = 0;
        end else if (seq_active !== 1'b1) begin
            blinks = 0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_led", 32'(led_out), 0);
        chk("rst_active", 32'(seq_active), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_done", 32'(seq_done), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // A: single code-3 request on id 2, dropped right after the grant
        set_code(2, 3);
        req = 4'b0100;
        sb.push_back('{2, 3});
        for (int j = 1; j <= 82; j++) begin
            tick();
            if (j == 1) begin
                chk("A_gid", 32'(grant_id), 2);
                req = '0;
            end
            chk("A_led", 32'(led_out),
                32'((j >= 1 && j <= 8) || (j >= 17 && j <= 24) || (j >= 33 && j <= 40)));
            chk("A_done", 32'(seq_done), 32'(j == 81));
            chk("A_active", 32'(seq_active), 32'(j <= 80));
        end

        // B: priority between id 1 (code 2) and id 3 (code 5), back-to-back regrant
        code = '0;
        set_code(1, 2);
        set_code(3, 5);
        req = 4'b1010;
        sb.push_back('{1, 2});
        sb.push_back('{1, 2});
        for (int j = 1; j <= 131; j++) begin
            tick();
            if (j == 1 || j == 66) chk("B_gid", 32'(grant_id), 1);
            if (j == 66) req = '0;
            chk("B_led", 32'(led_out),
                32'((j >= 1 && j <= 8) || (j >= 17 && j <= 24) ||
                    (j >= 66 && j <= 73) || (j >= 82 && j <= 89)));
            chk("B_done", 32'(seq_done), 32'(j == 65 || j == 130));
        end

        // C: id 3 code 4 running, id 0 arrives mid-sequence and must wait
        code = '0;
        set_code(3, 4);
        req = 4'b1000;
        sb.push_back('{3, 4});
        for (int j = 1; j <= 148; j++) begin
            tick();
            if (j == 17) begin
                set_code(0, 1);
                req = 4'b1001;
                sb.push_back('{0, 1});
            end
            if (j == 33) begin
                chk("C_nopreempt_gid", 32'(grant_id), 3);
                chk("C_nopreempt_led", 32'(led_out), 1);
            end
            if (j == 97) chk("C_gid_old", 32'(grant_id), 3);
            if (j == 98) begin
                chk("C_gid_new", 32'(grant_id), 0);
                chk("C_led_new", 32'(led_out), 1);
                req = '0;
            end
            chk("C_done", 32'(seq_done), 32'(j == 97 || j == 146));
        end
        chk("C_idle", 32'(seq_active), 0);

        // D: en dropped in the second OFF of a code-3 sequence, then restarted
        code = '0;
        set_code(2, 3);
        req = 4'b0100;
        for (int j = 1; j <= 111; j++) begin
            tick();
            if (j == 28) en = 1'b0;
            if (j == 29) begin
                chk("D_abort_led", 32'(led_out), 0);
                chk("D_abort_active", 32'(seq_active), 0);
                chk("D_abort_gid", 32'(grant_id), 2);
            end
            if (j == 30) begin
                chk("D_hold_idle", 32'(seq_active), 0);
                en = 1'b1;
                sb.push_back('{2, 3});
            end
            if (j == 31) begin
                chk("D_restart_led", 32'(led_out), 1);
                req = '0;
            end
            if (j == 47) chk("D_blink2_led", 32'(led_out), 1);
            chk("D_done", 32'(seq_done), 32'(j == 111));
        end

        // E: code 0 is never granted; code 15 gives 15 blinks over 272 cycles
        code = '0;
        set_code(1, 0);
        req = 4'b0010;
        for (int j = 1; j <= 40; j++) begin
            tick();
            chk("E_zero_led", 32'(led_out), 0);
            chk("E_zero_active", 32'(seq_active), 0);
        end
        set_code(1, 15);
        sb.push_back('{1, 15});
        on_cyc = 0;
        for (int j = 1; j <= 274; j++) begin
            tick();
            if (j == 1) req = '0;
            if (led_out === 1'b1) on_cyc++;
            if (j == 272) chk("E_active_last", 32'(seq_active), 1);
            chk("E_done", 32'(seq_done), 32'(j == 273));
        end
        chk("E_on_cycles", 32'(on_cyc), 120);

        // Reset in the middle of an ON phase
        code = '0;
        set_code(3, 2);
        req = 4'b1000;
        repeat (3) tick();
        chk("R_pre_gid", 32'(grant_id), 3);
        chk("R_pre_led", 32'(led_out), 1);
        rst_n = 1'b0;
        req   = '0;
        tick();
        chk("R_led", 32'(led_out), 0);
        chk("R_active", 32'(seq_active), 0);
        chk("R_gid", 32'(grant_id), 0);
        chk("R_done", 32'(seq_done), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("R_stay_idle", 32'(seq_active), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
